// File: rtl/regwrite_trace_fifo_if.sv
// Bundles the register-file write port seen by the trace FIFO together with
// the valid/ready drain port that carries trace entries to the consumer.
// master: processor/consumer side; slave: the trace FIFO.
interface regwrite_trace_fifo_if #(
  parameter int CYC_W = 16
);
  // Register-file write port from the processor writeback stage
  logic             in_we;
  logic [4:0]       in_rd;
  logic [31:0]      in_data;

  // Drain port toward the checker/logger
  logic             out_valid;
  logic             out_ready;
  logic [CYC_W-1:0] out_cycle;
  logic [4:0]       out_rd;
  logic [31:0]      out_data;

  modport master (
    output in_we, in_rd, in_data, out_ready,
    input  out_valid, out_cycle, out_rd, out_data
  );

  modport slave (
    input  in_we, in_rd, in_data, out_ready,
    output out_valid, out_cycle, out_rd, out_data
  );
endinterface

// File: rtl/regwrite_trace_fifo.sv
// Register-write trace FIFO: snoops the regfile write port and buffers every
// architectural register write (r0 excluded) as a {timestamp, rd, data} entry
// that drains through a valid/ready port. Writes arriving while the FIFO has
// no space are dropped and counted.
//
// Optional feature macro: REGWRITE_TRACE_TIMESTAMP_EN
//   defined   -> free-running cycle counter is present and each entry carries
//                the counter value sampled at capture.
//   undefined -> counter and its storage are removed; out_cycle reads 0.
module regwrite_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     capture_en,
  regwrite_trace_fifo_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int                 PTR_W    = $clog2(DEPTH);
  localparam int                 CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic [DROP_W-1:0]  DROP_MAX = {DROP_W{1'b1}};

  // Entry storage, one array per field so unused fields vanish cleanly
  logic [4:0]       mem_rd   [DEPTH];
  logic [31:0]      mem_data [DEPTH];
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
  logic [CYC_W-1:0] mem_cycle [DEPTH];
  logic [CYC_W-1:0] cycle_cnt;
`endif

  // Pointers are PTR_W bits wide and wrap naturally (DEPTH is a power of two)
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic cap;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Decode capture qualifier and push/pop/drop for this cycle
  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cap   = 1'b0;
    empty = 1'b0;
    full  = 1'b0;
    pop   = 1'b0;
    push  = 1'b0;
    drop  = 1'b0;

    cap   = capture_en & bus.in_we & (bus.in_rd != 5'd0);
    empty = (count == '0);
    full  = (count == FULL_CNT);
    // Pop needs a visible head entry; a same-cycle push into an empty FIFO
    // therefore never pops, so there is no fall-through.
    pop   = ~empty & bus.out_ready;
    // A full FIFO still has space when the head leaves in the same cycle.
    push  = cap & (~full | pop);
    drop  = cap & full & ~pop;
  end

  // Pointer and occupancy bookkeeping
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Write the captured entry into storage at the write pointer
  // NOTE: the storage arrays are deliberately not reset; the pointers and
  // count define which slots are live, so stale contents are never exposed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_rd[wr_ptr]    <= bus.in_rd;
      mem_data[wr_ptr]  <= bus.in_data;
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
      mem_cycle[wr_ptr] <= cycle_cnt;
`endif
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != DROP_MAX) drop_count <= drop_count + 1'b1;
    end
  end

`ifdef REGWRITE_TRACE_TIMESTAMP_EN
  // Free-running timestamp: 0 in the first cycle after reset, wraps at 2^CYC_W
  always_ff @(posedge clock) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 1'b1;
  end

  assign bus.out_cycle = mem_cycle[rd_ptr];
`else
  assign bus.out_cycle = {CYC_W{1'b0}};
`endif

  // Head entry is read straight from storage, so it holds while stalled
  assign bus.out_valid = ~empty;
  assign bus.out_rd    = mem_rd[rd_ptr];
  assign bus.out_data  = mem_data[rd_ptr];

endmodule

// File: tb/tb_regwrite_trace_fifo.sv
// Self-checking bench for regwrite_trace_fifo. A queue-based reference model
// tracks the trace contents from the capture/space/drop rules; a monitor on
// the falling edge compares the DUT's head entry and status against it.
// Honors REGWRITE_TRACE_TIMESTAMP_EN for the expected out_cycle values.
module tb_regwrite_trace_fifo;

  localparam int DEPTH  = 16;
  localparam int CYC_W  = 16;
  localparam int DROP_W = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct {
    logic [CYC_W-1:0] cyc;
    logic [4:0]       rd;
    logic [31:0]      data;
  } entry_t;

  logic clock;
  logic reset;
  logic capture_en;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  regwrite_trace_fifo_if #(.CYC_W(CYC_W)) bus ();

  regwrite_trace_fifo #(
    .DEPTH  (DEPTH),
    .CYC_W  (CYC_W),
    .DROP_W (DROP_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .capture_en (capture_en),
    .bus        (bus),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  entry_t            exp_q[$];
  logic [CYC_W-1:0]  m_ts;
  logic              m_ovf;
  int                m_drop;
  int                pop_cnt;
  bit                armed = 0;

  function automatic logic [CYC_W-1:0] exp_cycle(input logic [CYC_W-1:0] ts);
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
    return ts;
`else
    return '0;
`endif
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      exp_q.delete();
      m_ts   = '0;
      m_ovf  = 1'b0;
      m_drop = 0;
      armed  = 1;
    end else if (armed) begin
      if (bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pop_cnt++;
      end
      if (capture_en && bus.in_we && bus.in_rd != 5'd0) begin
        if (exp_q.size() < DEPTH) begin
          entry_t e;
          e.cyc  = exp_cycle(m_ts);
          e.rd   = bus.in_rd;
          e.data = bus.in_data;
          exp_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < (1 << DROP_W) - 1) m_drop++;
        end
      end
      m_ts = m_ts + 1'b1;
    end
  end

  // ---------------- monitor ----------------
  bit          hold_pending = 0;
  logic [4:0]  hold_rd;
  logic [31:0] hold_data;
  logic [31:0] last_out_data;

  always @(negedge clock) begin
    if (armed) begin
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      check("count", count, exp_q.size());
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drop);
      if (bus.out_valid && exp_q.size() != 0) begin
        check("out_rd", bus.out_rd, exp_q[0].rd);
        check("out_data", bus.out_data, exp_q[0].data);
        check("out_cycle", bus.out_cycle, exp_q[0].cyc);
      end
      if (hold_pending) begin
        check("hold_rd", bus.out_rd, hold_rd);
        check("hold_data", bus.out_data, hold_data);
      end
      hold_pending = bus.out_valid && !bus.out_ready && reset;
      hold_rd      = bus.out_rd;
      hold_data    = bus.out_data;
      if (bus.out_valid && bus.out_ready) last_out_data = bus.out_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    bus.in_we     = 1'b0;
    bus.in_rd     = 5'd0;
    bus.in_data   = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.out_ready = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic write(input logic [4:0] rd, input logic [31:0] data);
    bus.in_we   = 1'b1;
    bus.in_rd   = rd;
    bus.in_data = data;
    step();
    idle_inputs();
  endtask

  task automatic drain(input int max_cycles);
    idle_inputs();
    bus.out_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    @(negedge clock);
    check("drain_empty", count, 0);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int pc0;
    int pct;
    reset      = 1'b0;
    capture_en = 1'b1;
    bus.out_ready = 1'b0;
    idle_inputs();
    step();

    // Reset state
    do_reset();
    @(negedge clock);
    check("rst_valid", bus.out_valid, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_count, 0);

    // Write captured at timestamp 5
    do_reset();
    for (int i = 0; i < 5; i++) step();
    write(5'd3, 32'd42);
    @(negedge clock);
    check("t1_valid", bus.out_valid, 1);
    check("t1_rd", bus.out_rd, 3);
    check("t1_data", bus.out_data, 42);
    check("t1_cycle", bus.out_cycle, exp_cycle(16'd5));
    check("t1_count", count, 1);

    // r0 writes are never recorded
    write(5'd0, 32'd99);
    @(negedge clock);
    check("r0_count", count, 1);
    check("r0_overflow", overflow, 0);
    drain(10);

    // 18 writes into a stalled FIFO: two drops, first 16 drain in order
    do_reset();
    for (int i = 0; i < 18; i++) write(5'((i % 31) + 1), 32'd1000 + 32'(i));
    @(negedge clock);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    check("ovf_drop", drop_count, 2);
    pc0 = pop_cnt;
    drain(40);
    check("ovf_drained", pop_cnt - pc0, 16);
    check("ovf_last", last_out_data, 32'd1015);

    // Full FIFO with simultaneous pop and push
    do_reset();
    for (int i = 0; i < 16; i++) write(5'd9, 32'd2000 + 32'(i));
    bus.out_ready = 1'b1;
    write(5'd7, 32'h0000_abcd);
    @(negedge clock);
    check("fullpp_count", count, 16);
    check("fullpp_drop", drop_count, 0);
    drain(40);
    check("fullpp_last", last_out_data, 32'h0000_abcd);

    // Mid-operation reset flushes entries and clears overflow/timestamp
    do_reset();
    for (int i = 0; i < 18; i++) write(5'd4, 32'd3000 + 32'(i));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) step();
    bus.out_ready = 1'b0;
    @(negedge clock);
    check("mid_pre_count", count, 3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clock);
    check("mid_valid", bus.out_valid, 0);
    check("mid_count", count, 0);
    check("mid_overflow", overflow, 0);
    check("mid_drop", drop_count, 0);
    write(5'd12, 32'h1234_5678);
    @(negedge clock);
    check("mid_cycle0", bus.out_cycle, 0);
    check("mid_rd", bus.out_rd, 12);
    drain(10);

    // out_ready toggling while writes arrive every cycle
    do_reset();
    for (int i = 0; i < 60; i++) begin
      bus.out_ready = i[0];
      bus.in_we     = 1'b1;
      bus.in_rd     = 5'($urandom_range(1, 31));
      bus.in_data   = $urandom;
      step();
      if (i == 20) check("tog_nodrop", drop_count, 0);
    end
    drain(40);

    // Randomized traffic with varying drain pressure
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      pct = (blk % 3 == 0) ? 20 : (blk % 3 == 1) ? 85 : 50;
      for (int i = 0; i < 500; i++) begin
        capture_en    = ($urandom_range(0, 9) != 0);
        bus.in_we     = ($urandom_range(0, 2) != 0);
        bus.in_rd     = 5'($urandom_range(0, 31));
        bus.in_data   = $urandom;
        bus.out_ready = ($urandom_range(0, 99) < pct);
        step();
      end
    end
    capture_en = 1'b1;
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
